// File: rtl/lib_cpu.sv
// Shared CPU definitions: instruction width, NOP encoding and fetch FSM states.
package lib_cpu;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } FETCH_STATE;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [INSTR_W-1:0] align_word(input logic [INSTR_W-1:0] addr);
        return {addr[INSTR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch stage (master) and memory (slave).
interface fetch_unit_if;
    import lib_cpu::*;

    // imem_req/imem_ready handshake: a read completes in any cycle where both are
    // high, with imem_rdata valid in that same cycle. While imem_req is high and
    // imem_ready is low the master holds imem_addr stable.
    logic               imem_req;
    logic [INSTR_W-1:0] imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush (insert a NOP bubble) has priority over load.
module if_id_reg
    import lib_cpu::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [INSTR_W-1:0] pc_plus4_in,
    output logic [INSTR_W-1:0] instr,
    output logic [INSTR_W-1:0] pc_plus4,
    output logic               valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= INSTR_NOP;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (flush) begin
            instr <= INSTR_NOP;
            valid <= 1'b0;
        end else if (load) begin
            instr    <= instr_in;
            pc_plus4 <= pc_plus4_in;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem request FSM, redirect handling and the IF/ID register.
module fetch_unit
    import lib_cpu::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_unit_if.master       imem,
    input  logic               stall,
    input  logic               pc_src,
    input  logic [INSTR_W-1:0] branch_target,
    input  logic               jmp,
    input  logic [INSTR_W-1:0] jmp_target,
    output logic [INSTR_W-1:0] instr_id,
    output logic [INSTR_W-1:0] pc_plus4_id,
    output logic               valid_id,
    output FETCH_STATE         state
);

    FETCH_STATE         state_q, state_d;
    logic [INSTR_W-1:0] pc_q, pc_d;
    logic [INSTR_W-1:0] tgt_q, tgt_d;
    logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
    logic [INSTR_W-1:0] hold_pc4_q, hold_pc4_d;

    logic               redir;
    logic [INSTR_W-1:0] redir_tgt;
    logic [INSTR_W-1:0] pc_plus4;
    logic               req;
    logic               id_load;
    logic               id_flush;
    logic [INSTR_W-1:0] id_instr;
    logic [INSTR_W-1:0] id_pc4;

    assign redir     = jmp | pc_src;
    assign redir_tgt = align_word(jmp ? jmp_target : branch_target);
    assign pc_plus4  = pc_q + 32'd4;

    // Request is decoded from the registered state only, so an asynchronous
    // reset of state_q drops it immediately.
    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;
    assign state          = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            tgt_q        <= '0;
            hold_instr_q <= '0;
            hold_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            tgt_q        <= tgt_d;
            hold_instr_q <= hold_instr_d;
            hold_pc4_q   <= hold_pc4_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        hold_instr_d = hold_instr_q;
        hold_pc4_d   = hold_pc4_q;
        req          = 1'b0;
        id_load      = 1'b0;
        id_flush     = redir;
        id_instr     = imem.imem_rdata;
        id_pc4       = pc_plus4;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                req = 1'b1;
                if (redir) begin
                    if (imem.imem_ready) begin
                        pc_d = redir_tgt;
                    end else begin
                        // Address must stay put until the in-flight read finishes.
                        tgt_d   = redir_tgt;
                        state_d = DISCARD;
                    end
                end else if (imem.imem_ready) begin
                    pc_d = pc_plus4;
                    if (stall) begin
                        hold_instr_d = imem.imem_rdata;
                        hold_pc4_d   = pc_plus4;
                        state_d      = HOLD;
                    end else begin
                        id_load = 1'b1;
                    end
                end else if (!stall) begin
                    id_flush = 1'b1;
                end
            end
            HOLD: begin
                if (redir) begin
                    pc_d    = redir_tgt;
                    state_d = FETCH;
                end else if (!stall) begin
                    id_load  = 1'b1;
                    id_instr = hold_instr_q;
                    id_pc4   = hold_pc4_q;
                    state_d  = FETCH;
                end
            end
            DISCARD: begin
                req = 1'b1;
                if (redir) begin
                    tgt_d = redir_tgt;
                end
                if (imem.imem_ready) begin
                    // A redirect arriving in the completing cycle is the latest target.
                    pc_d    = redir ? redir_tgt : tgt_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (id_load),
        .flush       (id_flush),
        .instr_in    (id_instr),
        .pc_plus4_in (id_pc4),
        .instr       (instr_id),
        .pc_plus4    (pc_plus4_id),
        .valid       (valid_id)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit: sequential fetch, waits, stall/hold, redirects, wrap, reset.
module tb_fetch_unit;
    import lib_cpu::*;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic [31:0] instr_id;
    logic [31:0] pc_plus4_id;
    logic        valid_id;
    FETCH_STATE  state;

    int checks = 0;
    int errors = 0;

    fetch_unit_if imem_bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (imem_bus),
        .stall         (stall),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jmp           (jmp),
        .jmp_target    (jmp_target),
        .instr_id      (instr_id),
        .pc_plus4_id   (pc_plus4_id),
        .valid_id      (valid_id),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        stl;
        logic        br;
        logic [31:0] btgt;
        logic        jp;
        logic [31:0] jtgt;
        logic        exp_req;
        logic [31:0] exp_addr;
        FETCH_STATE  exp_st;
        logic        exp_valid;
        logic        chk_instr;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic vec_t mk(input logic rdy, input logic stl, input logic br,
                                input logic [31:0] btgt, input logic jp, input logic [31:0] jtgt,
                                input logic exp_req, input logic [31:0] exp_addr,
                                input FETCH_STATE exp_st, input logic exp_valid,
                                input logic chk_instr, input logic [31:0] exp_instr,
                                input logic [31:0] exp_pc4);
        vec_t r;
        r.rdy = rdy; r.stl = stl; r.br = br; r.btgt = btgt; r.jp = jp; r.jtgt = jtgt;
        r.exp_req = exp_req; r.exp_addr = exp_addr; r.exp_st = exp_st;
        r.exp_valid = exp_valid; r.chk_instr = chk_instr;
        r.exp_instr = exp_instr; r.exp_pc4 = exp_pc4;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req"},   {31'd0, imem_bus.imem_req}, 32'd0);
        chk({tag, "_addr"},  imem_bus.imem_addr, 32'h0000_0000);
        chk({tag, "_instr"}, instr_id, 32'h0);
        chk({tag, "_valid"}, {31'd0, valid_id}, 32'd0);
        chk({tag, "_state"}, {30'd0, state}, {30'd0, IDLE});
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0; pc_src = 1'b0; jmp = 1'b0;
        branch_target = '0; jmp_target = '0;
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = '0;

        // rdy stl br btgt jp jtgt | req addr state | valid chk instr pc4
        vecs.push_back(mk(1,0,0,0,0,0, 0,32'h0,IDLE,     0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0, 1,32'h0,FETCH,    1,1,pat(32'h0),32'h4));
        vecs.push_back(mk(1,0,0,0,0,0, 1,32'h4,FETCH,    1,1,pat(32'h4),32'h8));
        vecs.push_back(mk(0,0,0,0,0,0, 1,32'h8,FETCH,    0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,32'h8,FETCH,    0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,32'h8,FETCH,    0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0, 1,32'h8,FETCH,    1,1,pat(32'h8),32'hC));
        vecs.push_back(mk(1,0,0,0,0,0, 1,32'hC,FETCH,    1,1,pat(32'hC),32'h10));
        vecs.push_back(mk(1,1,0,0,0,0, 1,32'h10,FETCH,   1,1,pat(32'hC),32'h10));
        vecs.push_back(mk(1,1,0,0,0,0, 0,32'h14,HOLD,    1,1,pat(32'hC),32'h10));
        vecs.push_back(mk(1,0,0,0,0,0, 0,32'h14,HOLD,    1,1,pat(32'h10),32'h14));
        vecs.push_back(mk(1,0,0,0,0,0, 1,32'h14,FETCH,   1,1,pat(32'h14),32'h18));
        vecs.push_back(mk(1,0,0,0,0,0, 1,32'h18,FETCH,   1,1,pat(32'h18),32'h1C));
        vecs.push_back(mk(1,0,0,0,0,0, 1,32'h1C,FETCH,   1,1,pat(32'h1C),32'h20));
        // branch to 40 while request to 20 waits
        vecs.push_back(mk(0,0,1,32'h40,0,0, 1,32'h20,FETCH,   0,1,32'h0,0));
        vecs.push_back(mk(0,0,0,0,0,0,      1,32'h20,DISCARD, 0,1,32'h0,0));
        vecs.push_back(mk(1,0,0,0,0,0,      1,32'h20,DISCARD, 0,1,32'h0,0));
        vecs.push_back(mk(1,0,0,0,0,0,      1,32'h40,FETCH,   1,1,pat(32'h40),32'h44));
        // jump + branch + stall together: jump wins, flush
        vecs.push_back(mk(1,1,1,32'h200,1,32'h100, 1,32'h44,FETCH, 0,1,32'h0,0));
        vecs.push_back(mk(1,0,0,0,0,0,      1,32'h100,FETCH,  1,1,pat(32'h100),32'h104));
        // misaligned jump target
        vecs.push_back(mk(1,0,0,0,1,32'h103, 1,32'h104,FETCH, 0,1,32'h0,0));
        vecs.push_back(mk(1,0,0,0,0,0,      1,32'h100,FETCH,  1,1,pat(32'h100),32'h104));
        // jump to the top word, then PC wraps
        vecs.push_back(mk(1,0,0,0,1,32'hFFFF_FFFC, 1,32'h104,FETCH, 0,1,32'h0,0));
        vecs.push_back(mk(1,0,0,0,0,0,      1,32'hFFFF_FFFC,FETCH, 1,1,pat(32'hFFFF_FFFC),32'h0));
        vecs.push_back(mk(1,0,0,0,0,0,      1,32'h0,FETCH,    1,1,pat(32'h0),32'h4));
        // two redirects while pending: latest target wins
        vecs.push_back(mk(0,0,0,0,1,32'h80, 1,32'h4,FETCH,    0,1,32'h0,0));
        vecs.push_back(mk(0,0,1,32'h90,0,0, 1,32'h4,DISCARD,  0,1,32'h0,0));
        vecs.push_back(mk(1,0,0,0,0,0,      1,32'h4,DISCARD,  0,1,32'h0,0));
        vecs.push_back(mk(1,0,0,0,0,0,      1,32'h90,FETCH,   1,1,pat(32'h90),32'h94));
        // redirect while holding a stalled word
        vecs.push_back(mk(1,1,0,0,0,0,      1,32'h94,FETCH,   1,1,pat(32'h90),32'h94));
        vecs.push_back(mk(0,1,1,32'h200,0,0, 0,32'h98,HOLD,   0,1,32'h0,0));
        vecs.push_back(mk(1,0,0,0,0,0,      1,32'h200,FETCH,  1,1,pat(32'h200),32'h204));
        vecs.push_back(mk(0,0,0,0,0,0,      1,32'h204,FETCH,  0,0,0,0));

        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset");
        chk("reset_pc4", pc_plus4_id, 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("v%0d", i);
            imem_bus.imem_ready = vecs[i].rdy;
            imem_bus.imem_rdata = pat(vecs[i].exp_addr);
            stall         = vecs[i].stl;
            pc_src        = vecs[i].br;
            branch_target = vecs[i].btgt;
            jmp           = vecs[i].jp;
            jmp_target    = vecs[i].jtgt;
            #1;
            chk({tag, "_req"},   {31'd0, imem_bus.imem_req}, {31'd0, vecs[i].exp_req});
            chk({tag, "_addr"},  imem_bus.imem_addr, vecs[i].exp_addr);
            chk({tag, "_state"}, {30'd0, state}, {30'd0, vecs[i].exp_st});
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_valid"}, {31'd0, valid_id}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].chk_instr) chk({tag, "_instr"}, instr_id, vecs[i].exp_instr);
            if (vecs[i].exp_valid) chk({tag, "_pc4"}, pc_plus4_id, vecs[i].exp_pc4);
        end

        // Mid-run reset with a request outstanding: req must drop without a clock edge.
        imem_bus.imem_ready = 1'b0;
        stall = 1'b0; pc_src = 1'b0; jmp = 1'b0;
        #1;
        chk("midrst_pre_req", {31'd0, imem_bus.imem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = pat(32'h0);
        #1;
        chk("rerun_idle_req", {31'd0, imem_bus.imem_req}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rerun_req",  {31'd0, imem_bus.imem_req}, 32'd1);
        chk("rerun_addr", imem_bus.imem_addr, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rerun_instr", instr_id, pat(32'h0));
        chk("rerun_pc4",   pc_plus4_id, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined core. It owns the program counter, issues instruction-memory reads over a req/ready handshake, and delivers fetched words into the IF/ID pipeline register. It is the consumer of the redirect signals produced by decode control (`pc_src`, `jmp`) and of the hazard unit's stall, so it is the receiving end of the control path.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  read request.
- `imem_addr`  out  32  read address; always equals the PC register.
- `imem_ready`  in  1  completes the request this cycle; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `stall`  in  1  hold IF/ID contents (hazard unit).
- `pc_src`  in  1  taken branch, from decode control.
- `branch_target`  in  32  branch target address.
- `jmp`  in  1  jump, from decode control.
- `jmp_target`  in  32  jump target address.
- `instr_id`  out  32  IF/ID instruction.
- `pc_plus4_id`  out  32  IF/ID PC+4 of `instr_id`.
- `valid_id`  out  1  `instr_id` is a real instruction (0 = bubble).

## Operation
- The FSM has four states: IDLE, FETCH, HOLD and DISCARD.
- **Redirect:** `redir = jmp | pc_src`. The target is `jmp_target` when `jmp` is high, otherwise `branch_target`, so `jmp` has priority. Bits [1:0] of the target are forced to 0.
- **Flush:** any redirect clears IF/ID in the same edge, writing `valid_id`=0 and `instr_id`=32'h0. Flush wins over `stall`.
- **Request stability:** `imem_addr` must not change while `imem_req` is high and `imem_ready` is low.
- **IDLE:** entered on reset with `imem_req`=0. It goes to FETCH unconditionally on the next edge.
- **FETCH:** `imem_req`=1.
  - Redirect with ready: the returned word is dropped, PC is loaded with the target, and the FSM stays in FETCH.
  - Redirect without ready: the target is stored in `tgt_q` and the FSM goes to DISCARD.
  - Ready, no stall: IF/ID is loaded with {rdata, PC+4, valid=1}, PC becomes PC+4, and the FSM stays in FETCH.
  - Ready with stall: the word and PC+4 go into the hold buffer, PC becomes PC+4, IF/ID is unchanged, and the FSM goes to HOLD.
  - Not ready, no stall: `valid_id` becomes 0 (bubble).
  - Not ready with stall: IF/ID is unchanged.
- **HOLD:** `imem_req`=0.
  - Redirect: the hold buffer is discarded, PC is loaded with the target, and the FSM goes to FETCH.
  - Stall: the FSM stays in HOLD.
  - Otherwise: IF/ID is loaded from the hold buffer with valid=1, and the FSM goes to FETCH.
- **DISCARD:** `imem_req`=1 and the address stays at the old PC. `valid_id` stays 0.
  - A new redirect overwrites `tgt_q`; the latest target wins.
  - On `imem_ready`, the data is dropped, PC is loaded with `tgt_q`, and the FSM goes to FETCH.
- **Arithmetic:** PC+4 is computed as 32-bit and wraps modulo 2^32, so 32'hFFFF_FFFC becomes 32'h0.

## Timing
- **Reset values:**
  - `imem_req`=0
  - `imem_addr`=`RESET_PC`
  - `instr_id`=32'h0
  - `pc_plus4_id`=32'h0
  - `valid_id`=0
  - state=IDLE, `tgt_q`=0, hold buffer=0
- **First request:** the first `imem_req` is asserted in the cycle after `rst_n` rises.
- **Fetch latency:** if `imem_ready` is high at edge t, `instr_id` is valid after edge t. With zero-wait memory and no stalls, throughput is one instruction per cycle.
- **Redirect at cycle t with ready:** `imem_addr`=target from t+1.
- **Redirect at cycle t without ready:** `imem_addr`=target in the cycle after the discarded response completes.
- **Reset mid-operation:** `rst_n` low aborts any outstanding request immediately, since `imem_req` drops asynchronously. Buffered data is lost.
- **Stall and redirect in the same cycle:** the redirect takes effect; the stall applies only to IF/ID contents, which are flushed anyway.

## Structure
- **In `lib_cpu`:**
  - `FETCH_STATE` enum (IDLE, FETCH, HOLD, DISCARD)
  - `INSTR_NOP` = 32'h0
  - `INSTR_W` = 32
- **Sub-module `if_id_reg`:** the IF/ID register, with inputs load, flush, {instr, pc_plus4}, and outputs {instr, pc_plus4, valid}. Flush has priority over load.
- **Top level:** the PC register, the FSM, `tgt_q` and the hold buffer stay in `fetch_unit`.

## Test plan
- **Zero-wait sequential fetch:** reset release with `imem_ready`=1 and rdata=addr-based pattern -> `imem_addr` 0,4,8,C on consecutive cycles. `instr_id` follows one cycle later with `valid_id`=1 and `pc_plus4_id` 4,8,C,10.
- **Wait states:** `imem_ready` low for 3 cycles at addr 8 -> `imem_addr` held at 8, `valid_id`=0 for those cycles, then the word at 8 is delivered with `pc_plus4_id`=C.
- **Stall with data returning:** `stall`=1 for 2 cycles while the word at 10 returns -> FSM in HOLD, `imem_req`=0, IF/ID unchanged. On stall release, `instr_id`=word@10 and `imem_addr`=14.
- **Redirect during a pending request:** `pc_src`=1 with `branch_target`=40 while the request to 20 is pending -> `imem_addr` stays 20 until ready, that data is dropped, then `imem_addr`=40 and `valid_id` stays 0 throughout.
- **Simultaneous jump and branch:** `jmp`=1 (`jmp_target`=100) and `pc_src`=1 (`branch_target`=200), with `stall`=1 in the same cycle -> flush (`valid_id`=0, `instr_id`=0), next `imem_addr`=100.
- **Misaligned target, PC wrap, mid-run reset:**
  - `jmp_target`=32'h103 -> `imem_addr`=32'h100.
  - Fetch at FFFF_FFFC -> `pc_plus4_id`=0 and next address 0.
  - `rst_n` low mid-request -> `imem_req` drops to 0 immediately and `imem_addr`=`RESET_PC`.
